// File: rtl/if_stage_pkg.sv
// Core-wide definitions shared by the fetch and decode stages: address width,
// bubble encoding, fetch FSM states and the IF/ID pipeline register layout.
package if_stage_pkg;

  localparam int          ADDR_W    = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc4;
  } ifid_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection: reset, redirect target (word aligned),
// hold, or sequential PC+4 wrapping modulo 2^ADDR_W.
module if_stage_pc_reg #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;

  assign pc4 = pc_reg + FOUR;
  assign pc  = pc_reg;

  // Redirect outranks hold so a taken branch can break out of a stall.
  always_comb begin
    pc_next = pc4;
    if (redirect_valid) begin
      pc_next = redirect_pc & ALIGN_MASK;
    end else if (hold) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory reads and
// fills the IF/ID register, honouring stall, flush and redirect requests.
module if_stage #(
  parameter int                ADDR_W    = if_stage_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_read,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [15:0]       fetch_count
);

  import if_stage_pkg::*;

  // ADDR_W is expected to match the package width, since decode consumes ifid_t.
  fetch_state_t      state_reg, state_next;
  ifid_t             ifid_reg;
  logic [15:0]       count_reg;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic              pc_hold;
  logic              do_latch;
  logic              do_bubble;

  if_stage_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .hold           (pc_hold),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .pc4            (pc4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_RUN;
      S_RUN:   if (stall && !redirect_valid) state_next = S_HOLD;
      S_HOLD:  if (!stall || redirect_valid) state_next = S_RUN;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    imem_read = 1'b0;
    case (state_reg)
      S_RUN, S_HOLD: imem_read = 1'b1;
      default:       imem_read = 1'b0;
    endcase
  end

  // Edge behaviour follows the inputs; S_HOLD resumes fetch on the edge stall drops.
  assign pc_hold   = stall || (state_reg == S_RESET);
  assign do_bubble = redirect_valid || flush;
  assign do_latch  = (state_reg != S_RESET) && !do_bubble && !stall;

  always_ff @(posedge clk) begin
    if (rst || do_bubble) begin
      ifid_reg.valid <= 1'b0;
      ifid_reg.instr <= NOP_INSTR;
      ifid_reg.pc4   <= '0;
    end else if (do_latch) begin
      ifid_reg.valid <= 1'b1;
      ifid_reg.instr <= imem_data;
      ifid_reg.pc4   <= pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (do_latch && (count_reg != 16'hFFFF)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign imem_addr   = pc;
  assign ifid_valid  = ifid_reg.valid;
  assign ifid_instr  = ifid_reg.instr;
  assign ifid_pc4    = ifid_reg.pc4;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued as each step
// is driven and compared after the corresponding clock edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_read;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc4;
  logic [15:0] fetch_count;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  pc4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_read      (imem_read),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc4       (ifid_pc4),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expected IF/ID, then compare after the edge.
  task automatic step(input string tag, input logic st, input logic fl, input logic rv,
                      input logic [7:0] rpc, input logic ev, input logic [31:0] ei,
                      input logic [7:0] ep, input logic [7:0] ea, input logic [15:0] ec);
    exp_t e;
    stall          = st;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    sb.push_back('{valid: ev, instr: ei, pc4: ep});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
    check({tag, ".instr"}, ifid_instr, e.instr);
    check({tag, ".pc4"}, {24'd0, ifid_pc4}, {24'd0, e.pc4});
    check({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, ea});
    check({tag, ".read"}, {31'd0, imem_read}, 32'd1);
    check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, ec});
    $display("step %s: valid=%0b instr=%h pc4=%h addr=%h count=%0d",
             tag, ifid_valid, ifid_instr, ifid_pc4, imem_addr, fetch_count);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".read"}, {31'd0, imem_read}, 32'd0);
    check({tag, ".addr"}, {24'd0, imem_addr}, 32'h00);
    check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
    check({tag, ".instr"}, ifid_instr, 32'h0000_0000);
    check({tag, ".pc4"}, {24'd0, ifid_pc4}, 32'd0);
    check({tag, ".count"}, {16'd0, fetch_count}, 32'd0);
    $display("reset %s: read=%0b addr=%h valid=%0b count=%0d",
             tag, imem_read, imem_addr, ifid_valid, fetch_count);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hAC00_0000 | 32'(i);
    mem[0] = 32'h2001_0001;
    mem[1] = 32'h2002_0002;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    #1;
    check("post_rst.read", {31'd0, imem_read}, 32'd0);

    // First edge leaves S_RESET with no latch; then sequential fetch.
    step("boot",   0, 0, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 8'h00, 16'd0);
    step("fetch0", 0, 0, 0, 8'h00, 1, 32'h2001_0001, 8'h04, 8'h04, 16'd1);
    step("fetch1", 0, 0, 0, 8'h00, 1, 32'h2002_0002, 8'h08, 8'h08, 16'd2);

    for (int k = 0; k < 3; k++)
      step("stall", 1, 0, 0, 8'h00, 1, 32'h2002_0002, 8'h08, 8'h08, 16'd2);
    step("release", 0, 0, 0, 8'h00, 1, 32'hAC00_0002, 8'h0C, 8'h0C, 16'd3);

    step("stall2",   1, 0, 0, 8'h00, 1, 32'hAC00_0002, 8'h0C, 8'h0C, 16'd3);
    step("redir_st", 1, 0, 1, 8'h2B, 0, 32'h0000_0000, 8'h00, 8'h28, 16'd3);
    step("target",   0, 0, 0, 8'h00, 1, 32'hAC00_000A, 8'h2C, 8'h2C, 16'd4);

    step("redir_fc", 0, 0, 1, 8'hFC, 0, 32'h0000_0000, 8'h00, 8'hFC, 16'd4);
    step("wrap0",    0, 0, 0, 8'h00, 1, 32'hAC00_003F, 8'h00, 8'h00, 16'd5);
    step("wrap1",    0, 0, 0, 8'h00, 1, 32'h2001_0001, 8'h04, 8'h04, 16'd6);
    step("run8",     0, 0, 0, 8'h00, 1, 32'h2002_0002, 8'h08, 8'h08, 16'd7);
    step("run12",    0, 0, 0, 8'h00, 1, 32'hAC00_0002, 8'h0C, 8'h0C, 16'd8);
    step("run16",    0, 0, 0, 8'h00, 1, 32'hAC00_0003, 8'h10, 8'h10, 16'd9);
    step("flush",    0, 1, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 8'h14, 16'd9);

    // Free-run until the counter sits one below saturation.
    flush = 1'b0;
    for (int i = 0; i < 65525; i++) @(posedge clk);
    @(negedge clk);
    check("cnt_fffe", {16'd0, fetch_count}, 32'h0000_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("cnt_sat", {16'd0, fetch_count}, 32'h0000_FFFF);
      $display("sat: count=%h", fetch_count);
    end

    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40; stall = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_redir");
    rst = 1'b0;
    step("boot2",  0, 0, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 8'h00, 16'd0);
    step("fetch2", 0, 0, 0, 8'h00, 1, 32'h2001_0001, 8'h04, 8'h04, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
